// File: rtl/axi_dotp_pkg.sv
// Shared definitions for the AXI4-Lite dot-product target: register offsets,
// response codes, decode selectors and the MAC engine state encoding.
package axi_dotp_pkg;

    localparam int unsigned OFF_CTRL   = 'h000;
    localparam int unsigned OFF_STATUS = 'h004;
    localparam int unsigned OFF_LEN    = 'h008;
    localparam int unsigned OFF_RES_LO = 'h00C;
    localparam int unsigned OFF_RES_HI = 'h010;
    localparam int unsigned OFF_IER    = 'h014;
    localparam int unsigned OFF_A      = 'h100;
    localparam int unsigned OFF_B      = 'h200;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } dotp_state_e;

    typedef enum logic [3:0] {
        R_CTRL, R_STATUS, R_LEN, R_RES_LO, R_RES_HI, R_IER, R_MEM_A, R_MEM_B, R_NONE
    } reg_sel_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dotp_mac_engine.sv
// Sequential signed MAC engine: one element per cycle over LEN elements,
// 64-bit wrapping accumulator, RESULT/DONE loaded as the FSM enters FIN.
module dotp_mac_engine
    import axi_dotp_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_i,
    input  logic                                   done_clr_i,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1):0]   len_i,
    input  logic [31:0]                            a_i,
    input  logic [31:0]                            b_i,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] idx_o,
    output logic                                   done_o,
    output logic [63:0]                            result_o,
    output dotp_state_e                            state_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = IW + 1;

    dotp_state_e   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [63:0]   acc_q, acc_d;
    logic [63:0]   result_q, result_d;
    logic          done_q, done_d;

    logic [63:0]   a_ext, b_ext, prod;
    logic [LW-1:0] len_m1;

    // Sign-extend to 64 bits so the low 64 bits of the product are the signed product.
    assign a_ext  = {{32{a_i[31]}}, a_i};
    assign b_ext  = {{32{b_i[31]}}, b_i};
    assign prod   = a_ext * b_ext;
    assign len_m1 = len_i - LW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = done_q;
        if (done_clr_i) done_d = 1'b0;
        case (state_q)
            // FIN is already not busy, so a START landing there must be honoured too.
            IDLE, FIN: begin
                if (start_i) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_q + prod;
                idx_d = idx_q + IW'(1);
                if ({1'b0, idx_q} == len_m1) begin
                    result_d = acc_q + prod;
                    done_d   = 1'b1;
                    state_d  = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign idx_o    = idx_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign state_o  = state_q;

endmodule

// File: rtl/axi_lite_dotp_slave.sv
// AXI4-Lite target for the dot-product accelerator: channels, register decode,
// A/B vector memories. Optional DOTP_IRQ_EN adds irq, IER and W1C of DONE.
module axi_lite_dotp_slave
    import axi_dotp_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready
`ifdef DOTP_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = IW + 1;

    localparam logic [ADDR_W-3:0] W_CTRL   = (ADDR_W-2)'(OFF_CTRL   >> 2);
    localparam logic [ADDR_W-3:0] W_STATUS = (ADDR_W-2)'(OFF_STATUS >> 2);
    localparam logic [ADDR_W-3:0] W_LEN    = (ADDR_W-2)'(OFF_LEN    >> 2);
    localparam logic [ADDR_W-3:0] W_RES_LO = (ADDR_W-2)'(OFF_RES_LO >> 2);
    localparam logic [ADDR_W-3:0] W_RES_HI = (ADDR_W-2)'(OFF_RES_HI >> 2);
`ifdef DOTP_IRQ_EN
    localparam logic [ADDR_W-3:0] W_IER    = (ADDR_W-2)'(OFF_IER    >> 2);
`endif
    localparam logic [ADDR_W-9:0] PG_A     = (ADDR_W-8)'(OFF_A >> 8);
    localparam logic [ADDR_W-9:0] PG_B     = (ADDR_W-8)'(OFF_B >> 8);
    localparam logic [6:0]        DEPTH7   = 7'(DEPTH);

    // Handshakes: a beat transfers on the rising edge where valid and ready are both 1;
    // valid never waits on ready, and payload is held stable while valid && !ready.

    // Misaligned addresses are treated as unmapped.
    function automatic reg_sel_e decode(input logic [ADDR_W-1:0] addr);
        reg_sel_e sel;
        sel = R_NONE;
        if (addr[1:0] == 2'b00) begin
            if      (addr[ADDR_W-1:2] == W_CTRL)   sel = R_CTRL;
            else if (addr[ADDR_W-1:2] == W_STATUS) sel = R_STATUS;
            else if (addr[ADDR_W-1:2] == W_LEN)    sel = R_LEN;
            else if (addr[ADDR_W-1:2] == W_RES_LO) sel = R_RES_LO;
            else if (addr[ADDR_W-1:2] == W_RES_HI) sel = R_RES_HI;
`ifdef DOTP_IRQ_EN
            else if (addr[ADDR_W-1:2] == W_IER)    sel = R_IER;
`endif
            else if (addr[ADDR_W-1:8] == PG_A && {1'b0, addr[7:2]} < DEPTH7) sel = R_MEM_A;
            else if (addr[ADDR_W-1:8] == PG_B && {1'b0, addr[7:2]} < DEPTH7) sel = R_MEM_B;
        end
        return sel;
    endfunction

    logic              aw_valid_q, aw_valid_d;
    logic [ADDR_W-1:0] aw_addr_q;
    logic              w_valid_q, w_valid_d;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              awready_q, wready_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              arready_q, rvalid_q, rvalid_d;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;
    logic [LW-1:0]     len_q;
`ifdef DOTP_IRQ_EN
    logic              ier_q, irq_q;
`endif

    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];

    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic          busy, done;
    dotp_state_e   eng_state;
    logic [IW-1:0] eng_idx;
    logic [63:0]   result;

    reg_sel_e    wsel, rsel;
    logic        wr_err, start_req, do_start, do_len, do_mem_a, do_mem_b, do_ier, do_w1c;
    logic [31:0] len_merged;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    assign aw_hs  = s_awvalid & awready_q;
    assign w_hs   = s_wvalid & wready_q;
    assign b_hs   = bvalid_q & s_bready;
    assign ar_hs  = s_arvalid & arready_q;
    assign r_hs   = rvalid_q & s_rready;
    assign commit = aw_valid_q & w_valid_q & ~bvalid_q;
    assign busy   = (eng_state == RUN);

    // Address/data slots stay occupied until the B handshake, giving one outstanding write.
    assign aw_valid_d = b_hs ? 1'b0 : (aw_valid_q | aw_hs);
    assign w_valid_d  = b_hs ? 1'b0 : (w_valid_q | w_hs);
    assign rvalid_d   = ar_hs ? 1'b1 : (r_hs ? 1'b0 : rvalid_q);

    always_comb begin
        wsel       = decode(aw_addr_q);
        len_merged = apply_strb(32'(len_q), w_data_q, w_strb_q);
        wr_err     = 1'b0;
        start_req  = 1'b0;
        do_start   = 1'b0;
        do_len     = 1'b0;
        do_mem_a   = 1'b0;
        do_mem_b   = 1'b0;
        do_ier     = 1'b0;
        do_w1c     = 1'b0;
        case (wsel)
            R_CTRL: begin
                start_req = w_strb_q[0] & w_data_q[0];
                wr_err    = start_req & busy;
                do_start  = start_req & ~busy;
            end
`ifdef DOTP_IRQ_EN
            R_STATUS: do_w1c = w_strb_q[0] & w_data_q[1];
            R_IER:    do_ier = w_strb_q[0];
`endif
            R_LEN: begin
                if (busy || len_merged == 32'd0 || len_merged > 32'(DEPTH)) wr_err = 1'b1;
                else do_len = 1'b1;
            end
            R_MEM_A: begin
                wr_err   = busy;
                do_mem_a = ~busy;
            end
            R_MEM_B: begin
                wr_err   = busy;
                do_mem_b = ~busy;
            end
            default: wr_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            len_q      <= LW'(1);
        end else begin
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            awready_q  <= ~aw_valid_d;
            wready_q   <= ~w_valid_d;
            if (aw_hs) aw_addr_q <= s_awaddr;
            if (w_hs) begin
                w_data_q <= s_wdata;
                w_strb_q <= s_wstrb;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (b_hs) begin
                bvalid_q <= 1'b0;
            end
            if (commit && do_len) len_q <= len_merged[LW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (commit && do_mem_a)
            mem_a[aw_addr_q[IW+1:2]] <= apply_strb(mem_a[aw_addr_q[IW+1:2]], w_data_q, w_strb_q);
        if (commit && do_mem_b)
            mem_b[aw_addr_q[IW+1:2]] <= apply_strb(mem_b[aw_addr_q[IW+1:2]], w_data_q, w_strb_q);
    end

    // Read data is a snapshot of the registers as they stand in the accept cycle.
    always_comb begin
        rsel    = decode(s_araddr);
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rsel)
            R_CTRL:   rd_data = '0;
            R_STATUS: rd_data = {30'd0, done, busy};
            R_LEN:    rd_data = 32'(len_q);
            R_RES_LO: rd_data = result[31:0];
            R_RES_HI: rd_data = result[63:32];
`ifdef DOTP_IRQ_EN
            R_IER:    rd_data = {31'd0, ier_q};
`endif
            R_MEM_A:  rd_data = mem_a[s_araddr[IW+1:2]];
            R_MEM_B:  rd_data = mem_b[s_araddr[IW+1:2]];
            default:  rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            arready_q <= ~rvalid_d;
            rvalid_q  <= rvalid_d;
            if (ar_hs) begin
                rdata_q <= rd_data;
                rresp_q <= rd_resp;
            end
        end
    end

`ifdef DOTP_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ier_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (commit && do_ier) ier_q <= w_data_q[0];
            irq_q <= done & ier_q;
        end
    end
    assign irq = irq_q;
`endif

    dotp_mac_engine #(.DEPTH(DEPTH)) u_engine (
        .clk        (clk),
        .rst        (rst),
        .start_i    (commit & do_start),
        .done_clr_i (commit & do_w1c),
        .len_i      (len_q),
        .a_i        (mem_a[eng_idx]),
        .b_i        (mem_b[eng_idx]),
        .idx_o      (eng_idx),
        .done_o     (done),
        .result_o   (result),
        .state_o    (eng_state)
    );

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_dotp_slave.sv
// Directed self-checking bench for axi_lite_dotp_slave (DEPTH=16); IRQ steps
// are compiled in when DOTP_IRQ_EN is defined.
module tb_axi_lite_dotp_slave;
    import axi_dotp_pkg::*;

    localparam int DEPTH = 16;

    logic        clk, rst;
    logic [11:0] s_awaddr, s_araddr;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
`ifdef DOTP_IRQ_EN
    logic        irq;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    axi_lite_dotp_slave #(.DEPTH(DEPTH), .ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
`ifdef DOTP_IRQ_EN
        , .irq(irq)
`endif
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks: all entered and left #1 after a rising edge.
    task automatic axi_write_nob(input logic [11:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        s_awaddr = addr; s_awvalid = 1'b1;
        s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            step(); n++;
            if (aw_hs) begin aw_done = 1; s_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  s_wvalid = 1'b0; end
        end
        check("wr_accept", {aw_done, w_done}, 2'b11);
        n = 0;
        while (!s_bvalid && n < 20) begin step(); n++; end
        check("bvalid_seen", s_bvalid, 1'b1);
        resp = s_bresp;
    endtask

    task automatic b_ack();
        s_bready = 1'b1;
        step();
        s_bready = 1'b0;
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        axi_write_nob(addr, data, strb, resp);
        b_ack();
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ar_hs, ar_done;
        int n;
        ar_done = 0; n = 0;
        s_araddr = addr; s_arvalid = 1'b1;
        while (!ar_done && n < 20) begin
            ar_hs = s_arvalid && s_arready;
            step(); n++;
            if (ar_hs) begin ar_done = 1; s_arvalid = 1'b0; end
        end
        check("rd_accept", ar_done, 1'b1);
        n = 0;
        while (!s_rvalid && n < 20) begin step(); n++; end
        check("rvalid_seen", s_rvalid, 1'b1);
        data = s_rdata; resp = s_rresp;
        s_rready = 1'b1;
        step();
        s_rready = 1'b0;
    endtask

    task automatic wait_done();
        logic [31:0] st;
        logic [1:0]  rs;
        int n;
        n = 0; st = '0;
        while (!st[1] && n < 30) begin
            axi_read(12'(OFF_STATUS), st, rs);
            n++;
        end
        check("done_poll", st[1], 1'b1);
    endtask

    logic [31:0] rd;
    logic [1:0]  rsp;

    initial begin
        // Reset phase
        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
        s_araddr = '0; s_arvalid = 0; s_rready = 0;
        step(); step();
        check("rst_awready", s_awready, 1'b0);
        check("rst_wready", s_wready, 1'b0);
        check("rst_bvalid", s_bvalid, 1'b0);
        check("rst_arready", s_arready, 1'b0);
        check("rst_rvalid", s_rvalid, 1'b0);
        check("rst_bresp", s_bresp, 2'b00);
        check("rst_rresp", s_rresp, 2'b00);
        check("rst_rdata", s_rdata, 32'h0);
        rst = 1'b0;
        step();
        axi_read(12'(OFF_STATUS), rd, rsp); check("rst_status", rd, 32'h0);
        check("rst_status_resp", rsp, RESP_OKAY);
        axi_read(12'(OFF_LEN), rd, rsp);    check("rst_len", rd, 32'h1);
        axi_read(12'(OFF_RES_LO), rd, rsp); check("rst_res_lo", rd, 32'h0);
        axi_read(12'(OFF_RES_HI), rd, rsp); check("rst_res_hi", rd, 32'h0);

        // A=[1,2,3,4], B=[5,6,7,8], LEN=4 -> 70, with per-cycle BUSY/DONE timing
        for (int i = 0; i < 4; i++) begin
            axi_write(12'(OFF_A + 4*i), 32'(i + 1), 4'hF, rsp); check("wr_a_resp", rsp, RESP_OKAY);
            axi_write(12'(OFF_B + 4*i), 32'(i + 5), 4'hF, rsp); check("wr_b_resp", rsp, RESP_OKAY);
        end
        axi_write(12'(OFF_LEN), 32'd4, 4'hF, rsp); check("wr_len4_resp", rsp, RESP_OKAY);
        axi_write_nob(12'(OFF_CTRL), 32'h1, 4'hF, rsp); check("start_resp", rsp, RESP_OKAY);
        for (int k = 1; k <= 5; k++) begin
            check("busy_timing", dut.busy, (k <= 4));
            check("done_timing", dut.done, (k == 5));
            if (k == 1) s_bready = 1'b1;
            step();
            s_bready = 1'b0;
        end
        axi_read(12'(OFF_RES_LO), rd, rsp); check("res_lo_70", rd, 32'd70);
        axi_read(12'(OFF_RES_HI), rd, rsp); check("res_hi_70", rd, 32'd0);
        axi_read(12'(OFF_STATUS), rd, rsp); check("status_done", rd, 32'h2);

        // Signed: -3 * 7 = -21
        axi_write(12'(OFF_A), 32'hFFFF_FFFD, 4'hF, rsp);
        axi_write(12'(OFF_B), 32'd7, 4'hF, rsp);
        axi_write(12'(OFF_LEN), 32'd1, 4'hF, rsp); check("wr_len1_resp", rsp, RESP_OKAY);
        axi_write(12'(OFF_CTRL), 32'h1, 4'hF, rsp);
        wait_done();
        axi_read(12'(OFF_RES_LO), rd, rsp); check("res_lo_neg", rd, 32'hFFFF_FFEB);
        axi_read(12'(OFF_RES_HI), rd, rsp); check("res_hi_neg", rd, 32'hFFFF_FFFF);

        // Error responses and byte strobes
        axi_write(12'(OFF_LEN), 32'd0, 4'hF, rsp);  check("len0_slverr", rsp, RESP_SLVERR);
        axi_write(12'(OFF_LEN), 32'd17, 4'hF, rsp); check("len17_slverr", rsp, RESP_SLVERR);
        axi_read(12'(OFF_LEN), rd, rsp); check("len_unchanged", rd, 32'd1);
        axi_read(12'h300, rd, rsp); check("unmapped_rresp", rsp, RESP_SLVERR);
        check("unmapped_rdata", rd, 32'h0);
        axi_write(12'(OFF_RES_LO), 32'h5, 4'hF, rsp); check("ro_slverr", rsp, RESP_SLVERR);
`ifndef DOTP_IRQ_EN
        axi_write(12'(OFF_IER), 32'h1, 4'hF, rsp);    check("ier_unmapped", rsp, RESP_SLVERR);
        axi_write(12'(OFF_STATUS), 32'h2, 4'hF, rsp); check("status_ro", rsp, RESP_SLVERR);
`endif
        axi_write(12'(OFF_A + 20), 32'h1122_3344, 4'hF, rsp);
        axi_write(12'(OFF_A + 20), 32'hAABB_CCDD, 4'b0101, rsp); check("strb_mem_resp", rsp, RESP_OKAY);
        axi_read(12'(OFF_A + 20), rd, rsp); check("strb_mem", rd, 32'h11BB_33DD);
        axi_write(12'(OFF_LEN), 32'h0000_0A03, 4'b0001, rsp); check("strb_len_resp", rsp, RESP_OKAY);
        axi_read(12'(OFF_LEN), rd, rsp); check("strb_len", rd, 32'd3);

        // W three cycles ahead of AW, then bready held low for 5 cycles
        s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
        check("w_first_wready", s_wready, 1'b1);
        step();
        s_wvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("w_first_no_b", s_bvalid, 1'b0);
            check("w_first_wready_low", s_wready, 1'b0);
            step();
        end
        s_awaddr = 12'(OFF_A + 24); s_awvalid = 1'b1;
        check("aw_late_awready", s_awready, 1'b1);
        step();
        s_awvalid = 1'b0;
        for (int k = 0; k < 5 && !s_bvalid; k++) step();
        check("bp_bvalid", s_bvalid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("bp_bvalid_hold", s_bvalid, 1'b1);
            check("bp_bresp_hold", s_bresp, RESP_OKAY);
            check("bp_awready_low", s_awready, 1'b0);
            step();
        end
        s_bready = 1'b1;
        step();
        s_bready = 1'b0;
        check("bp_bvalid_clr", s_bvalid, 1'b0);
        check("bp_awready_reopen", s_awready, 1'b1);
        step(); step();
        check("bp_single_b", s_bvalid, 1'b0);
        axi_read(12'(OFF_A + 24), rd, rsp); check("bp_data", rd, 32'hCAFE_F00D);

        // rready held low
        s_araddr = 12'(OFF_A + 20); s_arvalid = 1'b1;
        check("rbp_arready", s_arready, 1'b1);
        step();
        s_arvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rbp_rvalid", s_rvalid, 1'b1);
            check("rbp_rdata", s_rdata, 32'h11BB_33DD);
            check("rbp_arready_low", s_arready, 1'b0);
            step();
        end
        s_rready = 1'b1;
        step();
        s_rready = 1'b0;
        check("rbp_rvalid_clr", s_rvalid, 1'b0);

        // LEN=16 run, A[i]=i+1, B[i]=2 -> 272; writes during BUSY are rejected
        for (int i = 0; i < DEPTH; i++) begin
            axi_write(12'(OFF_A + 4*i), 32'(i + 1), 4'hF, rsp);
            axi_write(12'(OFF_B + 4*i), 32'd2, 4'hF, rsp);
        end
        axi_write(12'(OFF_LEN), 32'd16, 4'hF, rsp); check("len16_resp", rsp, RESP_OKAY);
        axi_write(12'(OFF_CTRL), 32'h1, 4'hF, rsp); check("start16_resp", rsp, RESP_OKAY);
        axi_write(12'(OFF_CTRL), 32'h1, 4'hF, rsp); check("start_busy", rsp, RESP_SLVERR);
        axi_write(12'(OFF_A), 32'h55, 4'hF, rsp);   check("mem_busy", rsp, RESP_SLVERR);
        axi_write(12'(OFF_LEN), 32'd2, 4'hF, rsp);  check("len_busy", rsp, RESP_SLVERR);
        axi_read(12'(OFF_STATUS), rd, rsp); check("status_busy", rd, 32'h1);
        wait_done();
        axi_read(12'(OFF_RES_LO), rd, rsp); check("res_lo_272", rd, 32'd272);
        axi_read(12'(OFF_RES_HI), rd, rsp); check("res_hi_272", rd, 32'd0);
        axi_read(12'(OFF_A), rd, rsp); check("a0_kept", rd, 32'd1);

        // Reset in the middle of RUN with a write and a read in flight
        axi_write(12'(OFF_CTRL), 32'h1, 4'hF, rsp);
        s_awaddr = 12'(OFF_A); s_awvalid = 1'b1; s_wdata = 32'h77; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_araddr = 12'(OFF_STATUS); s_arvalid = 1'b1;
        step();
        rst = 1'b1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        #1;
        check("mid_rst_busy", dut.busy, 1'b0);
        check("mid_rst_done", dut.done, 1'b0);
        check("mid_rst_bvalid", s_bvalid, 1'b0);
        check("mid_rst_rvalid", s_rvalid, 1'b0);
        check("mid_rst_awready", s_awready, 1'b0);
        step();
        rst = 1'b0;
        step(); step();
        check("post_rst_no_b", s_bvalid, 1'b0);
        axi_read(12'(OFF_LEN), rd, rsp); check("post_rst_len", rd, 32'd1);
        axi_read(12'(OFF_A), rd, rsp); check("post_rst_a0", rd, 32'd1);
        axi_write(12'(OFF_LEN), 32'd3, 4'hF, rsp);
        axi_write(12'(OFF_CTRL), 32'h1, 4'hF, rsp); check("post_rst_start", rsp, RESP_OKAY);
        wait_done();
        axi_read(12'(OFF_RES_LO), rd, rsp); check("post_rst_res", rd, 32'd12);

`ifdef DOTP_IRQ_EN
        // irq one cycle after DONE, cleared by W1C of STATUS bit1
        axi_write(12'(OFF_IER), 32'h1, 4'hF, rsp); check("ier_resp", rsp, RESP_OKAY);
        axi_write(12'(OFF_LEN), 32'd1, 4'hF, rsp);
        axi_write_nob(12'(OFF_CTRL), 32'h1, 4'hF, rsp);
        check("irq_during_run", irq, 1'b0);
        b_ack();
        check("irq_done_cycle_done", dut.done, 1'b1);
        check("irq_done_cycle_irq", irq, 1'b0);
        step();
        check("irq_rise", irq, 1'b1);
        axi_write(12'(OFF_STATUS), 32'h2, 4'hF, rsp); check("w1c_resp", rsp, RESP_OKAY);
        check("irq_clr", irq, 1'b0);
        axi_read(12'(OFF_STATUS), rd, rsp); check("w1c_status", rd, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
